alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
// - Issuing side of the ALU command interface: accepts one command (function code + two operands) from the
//   system controller, drives ALU_FUN/ALU_A/ALU_B and pulses Enable_ALU, waits for the ALU result, returns it.
// - Sits between the system-controller FSM and the ALU; owns Enable_ALU, so the ALU's unit decoder only sees
//   enable for exactly one cycle per command (low-power: operand/function lines do not toggle between commands).
// PARAMETERS
// - DATA_WIDTH  8   operand width; result width is 2*DATA_WIDTH
// - FUN_WIDTH   4   ALU function code width; [FUN_WIDTH-1:FUN_WIDTH-2] = unit select, low bits = op within unit
// - TIMEOUT     15  max cycles waited for ALU_Valid after the enable pulse (>=2)
// PORTS
// - CLK          in   1              system clock (single domain)
// - RST          in   1              reset, asynchronous, active-low
// - Cmd_Valid    in   1              command present
// - Cmd_Ready    out  1              issuer can accept a command
// - Cmd_Fun      in   FUN_WIDTH      requested ALU function
// - Cmd_A        in   DATA_WIDTH     operand A
// - Cmd_B        in   DATA_WIDTH     operand B
// - ALU_FUN      out  FUN_WIDTH      function code to ALU (held between commands)
// - ALU_A        out  DATA_WIDTH     operand A to ALU (held)
// - ALU_B        out  DATA_WIDTH     operand B to ALU (held)
// - Enable_ALU   out  1              one-cycle ALU enable pulse (registered)
// - ALU_Result   in   2*DATA_WIDTH   ALU output
// - ALU_Valid    in   1              ALU output valid
// - Res_Data     out  2*DATA_WIDTH   captured result (0 on timeout)
// - Res_Valid    out  1              result available
// - Res_Ready    in   1              consumer accepts result
// - Res_Err      out  1              result is a timeout, qualified by Res_Valid
// - Busy         out  1              high in every state except IDLE
// BEHAVIOUR
// - Reset (RST=0, any time, mid-command included): state IDLE, all outputs 0 (Cmd_Ready rises after release);
//   wait counter 0; in-flight command dropped, no result produced.
// - States: IDLE, ISSUE, WAIT, RESP. Cmd_Ready = (state==IDLE), combinational.
// - IDLE: Cmd_Valid=1 -> register Cmd_Fun/A/B onto ALU_FUN/ALU_A/ALU_B, go ISSUE. Else hold all outputs.
// - ISSUE: Enable_ALU=1 for exactly this one cycle; counter cleared; -> WAIT. ALU_Valid here is stale, ignored.
// - WAIT: Enable_ALU=0; counter increments each cycle. ALU_Valid=1 -> Res_Data<=ALU_Result, Res_Err<=0, -> RESP.
//   Counter reaches TIMEOUT with no ALU_Valid -> Res_Data<=0, Res_Err<=1, -> RESP. ALU_Valid on the
//   same cycle as expiry wins (result captured, Res_Err=0).
// - RESP: Res_Valid=1, Res_Data/Res_Err stable until Res_Ready=1 -> IDLE (Res_Valid low next cycle).
//   ALU_Valid in RESP/IDLE ignored; Cmd_Valid in non-IDLE states ignored (not consumed).
// - Latency: Cmd accept (cycle 0) -> Enable_ALU cycle 1 -> Res_Valid earliest cycle 3 with single-cycle ALU.
// - Throughput: one command outstanding; next accepted the cycle after Res_Ready handshake.
// - Any FUN code accepted verbatim; unit decode is the ALU's job. Counter width = clog2(TIMEOUT+1).
// STRUCTURE
// - Package alu_issuer_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), unit-select codes
//   (ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11), default widths.
// - One sub-module: alu_wait_timer (clear/enable counter, expired flag at TIMEOUT); rest in top FSM.
// TESTING
// - Basic: Cmd_Fun=4'h0, A=8'd7, B=8'd5; ALU_Valid with 16'd12 two cycles after enable -> Res_Data=12, Res_Err=0.
// - Enable pulse: any command -> Enable_ALU high exactly 1 cycle; ALU_FUN/A/B unchanged until next accept.
// - Timeout: TIMEOUT=15, never assert ALU_Valid -> Res_Valid 15 cycles into WAIT, Res_Err=1, Res_Data=0.
// - Backpressure: hold Res_Ready=0 for 10 cycles, pulse ALU_Valid/new Cmd_Valid meanwhile ->
//   Res_Data unchanged, Cmd_Ready=0, command not consumed; Res_Ready=1 -> IDLE, then Cmd accepted.
// - Edge race: ALU_Valid on expiry cycle with 16'hBEEF -> Res_Data=16'hBEEF, Res_Err=0.
// - Reset mid-WAIT: RST=0 one cycle -> all outputs 0, IDLE; late ALU_Valid -> no Res_Valid.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
// Shared types and defaults for the ALU command issuer.
package alu_issuer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FUN_WIDTH  = 4;
    localparam int DEF_TIMEOUT    = 15;

    // Issuer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issuer_state_t;

    // Unit-select codes carried in the top two bits of the function code.
    // The issuer forwards function codes verbatim; these are for the ALU side.
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

// File: rtl/alu_wait_timer.sv
// Up-counter bounding how long the issuer waits for the ALU result.
// expired marks the cycle on which the count steps up to TIMEOUT.
module alu_wait_timer
    import alu_issuer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Clear wins over enable; the count saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_issuer.sv
// Issuing side of the ALU command interface.
//
// state | meaning
// IDLE  | ready for a command; ALU operand/function lines held
// ISSUE | Enable_ALU high for this single cycle; wait timer cleared
// WAIT  | waiting for ALU_Valid or timer expiry
// RESP  | result presented until Res_Ready
module alu_op_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FUN_WIDTH  = DEF_FUN_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Cmd_Valid,
    output logic                    Cmd_Ready,
    input  logic [FUN_WIDTH-1:0]    Cmd_Fun,
    input  logic [DATA_WIDTH-1:0]   Cmd_A,
    input  logic [DATA_WIDTH-1:0]   Cmd_B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic                    Enable_ALU,
    input  logic [2*DATA_WIDTH-1:0] ALU_Result,
    input  logic                    ALU_Valid,
    output logic [2*DATA_WIDTH-1:0] Res_Data,
    output logic                    Res_Valid,
    input  logic                    Res_Ready,
    output logic                    Res_Err,
    output logic                    Busy
);

    issuer_state_t state_q, state_d;
    logic          wait_expired;
    logic          accept;
    logic          finish;

    alu_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .clr     (state_q == ISSUE),
        .en      (state_q == WAIT),
        .expired (wait_expired)
    );

    assign accept = (state_q == IDLE) && Cmd_Valid;
    assign finish = (state_q == WAIT) && (ALU_Valid || wait_expired);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Cmd_Valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ALU_Valid || wait_expired) state_d = RESP;
            RESP:    if (Res_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand/function capture, enable pulse and result capture; ALU_Valid beats expiry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_FUN    <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            Enable_ALU <= 1'b0;
            Res_Data   <= '0;
            Res_Err    <= 1'b0;
        end else begin
            Enable_ALU <= accept;
            if (accept) begin
                ALU_FUN <= Cmd_Fun;
                ALU_A   <= Cmd_A;
                ALU_B   <= Cmd_B;
            end
            if (finish) begin
                Res_Data <= ALU_Valid ? ALU_Result : '0;
                Res_Err  <= !ALU_Valid;
            end
        end
    end

    // Cmd_Ready is held low while reset is asserted so it only rises after release.
    assign Cmd_Ready = RST && (state_q == IDLE);
    assign Res_Valid = (state_q == RESP);
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with an expected-result queue.
module tb_alu_op_issuer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic [3:0]  Cmd_Fun;
    logic [7:0]  Cmd_A;
    logic [7:0]  Cmd_B;
    logic [3:0]  ALU_FUN;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic        Enable_ALU;
    logic [15:0] ALU_Result;
    logic        ALU_Valid;
    logic [15:0] Res_Data;
    logic        Res_Valid;
    logic        Res_Ready;
    logic        Res_Err;
    logic        Busy;

    int n_pass  = 0;
    int n_total = 0;

    // {err, data}
    logic [16:0] sb[$];

    alu_op_issuer #(
        .DATA_WIDTH (8),
        .FUN_WIDTH  (4),
        .TIMEOUT    (15)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Cmd_Valid  (Cmd_Valid),
        .Cmd_Ready  (Cmd_Ready),
        .Cmd_Fun    (Cmd_Fun),
        .Cmd_A      (Cmd_A),
        .Cmd_B      (Cmd_B),
        .ALU_FUN    (ALU_FUN),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .Enable_ALU (Enable_ALU),
        .ALU_Result (ALU_Result),
        .ALU_Valid  (ALU_Valid),
        .Res_Data   (Res_Data),
        .Res_Valid  (Res_Valid),
        .Res_Ready  (Res_Ready),
        .Res_Err    (Res_Err),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sb_check();
        logic [16:0] e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("res_data", 32'(Res_Data), 32'(e[15:0]));
            chk("res_err", 32'(Res_Err), 32'(e[16]));
        end
    endtask

    // Accept a command from IDLE; returns sampled in the first WAIT cycle.
    task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                         input bit stale);
        chk("cmd_ready_idle", 32'(Cmd_Ready), 32'd1);
        Cmd_Valid = 1'b1; Cmd_Fun = f; Cmd_A = a; Cmd_B = b;
        step();
        Cmd_Valid = 1'b0; Cmd_Fun = ~f; Cmd_A = ~a; Cmd_B = ~b;
        chk("enable_pulse_hi", 32'(Enable_ALU), 32'd1);
        chk("alu_fun", 32'(ALU_FUN), 32'(f));
        chk("alu_a", 32'(ALU_A), 32'(a));
        chk("alu_b", 32'(ALU_B), 32'(b));
        chk("cmd_ready_busy", 32'(Cmd_Ready), 32'd0);
        chk("busy_issue", 32'(Busy), 32'd1);
        if (stale) begin
            ALU_Valid = 1'b1; ALU_Result = 16'hDEAD;
        end
        step();
        ALU_Valid = 1'b0;
        chk("enable_pulse_lo", 32'(Enable_ALU), 32'd0);
        chk("alu_a_held", 32'(ALU_A), 32'(a));
        chk("no_res_in_wait", 32'(Res_Valid), 32'd0);
    endtask

    // Stay in WAIT for 'dly' cycles, then present one ALU_Valid beat.
    task automatic alu_respond(input int dly, input logic [15:0] r);
        repeat (dly) step();
        ALU_Valid = 1'b1; ALU_Result = r;
        step();
        ALU_Valid = 1'b0; ALU_Result = 16'h5A5A;
    endtask

    // Bounded wait for Res_Valid, scoreboard compare, then handshake.
    task automatic collect();
        int i;
        i = 0;
        while (!Res_Valid && i < 40) begin
            step();
            i++;
        end
        chk("res_valid_seen", 32'(Res_Valid), 32'd1);
        if (Res_Valid) sb_check();
        Res_Ready = 1'b1;
        step();
        Res_Ready = 1'b0;
        chk("res_valid_drop", 32'(Res_Valid), 32'd0);
        chk("cmd_ready_back", 32'(Cmd_Ready), 32'd1);
    endtask

    initial begin
        RST = 1'b0; Cmd_Valid = 1'b0; Cmd_Fun = '0; Cmd_A = '0; Cmd_B = '0;
        ALU_Result = '0; ALU_Valid = 1'b0; Res_Ready = 1'b0;
        step(); step();
        chk("rst_cmd_ready", 32'(Cmd_Ready), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_enable", 32'(Enable_ALU), 32'd0);
        chk("rst_res_valid", 32'(Res_Valid), 32'd0);
        chk("rst_res_data", 32'(Res_Data), 32'd0);
        chk("rst_alu_a", 32'(ALU_A), 32'd0);
        RST = 1'b1;
        #1;

        // basic add: result two cycles after the enable pulse
        issue(4'h0, 8'd7, 8'd5, 1'b0);
        sb.push_back({1'b0, 16'd12});
        alu_respond(1, 16'd12);
        collect();
        chk("fun_held_idle", 32'(ALU_FUN), 32'h0);
        chk("a_held_idle", 32'(ALU_A), 32'd7);
        chk("b_held_idle", 32'(ALU_B), 32'd5);

        // single-cycle ALU: Res_Valid right after the valid beat; stale valid in ISSUE ignored
        step();
        issue(4'h5, 8'hF0, 8'h3C, 1'b1);
        sb.push_back({1'b0, 16'h0030});
        alu_respond(0, 16'h0030);
        chk("latency_res_valid", 32'(Res_Valid), 32'd1);
        collect();

        // timeout: nothing from the ALU, result 15 cycles into WAIT
        issue(4'h8, 8'd1, 8'd2, 1'b0);
        sb.push_back({1'b1, 16'h0000});
        ALU_Result = 16'hFFFF;
        repeat (14) step();
        chk("timeout_not_early", 32'(Res_Valid), 32'd0);
        step();
        chk("timeout_res_valid", 32'(Res_Valid), 32'd1);
        collect();

        // valid on the expiry cycle wins
        issue(4'hC, 8'd3, 8'd4, 1'b0);
        sb.push_back({1'b0, 16'hBEEF});
        repeat (14) step();
        chk("race_not_early", 32'(Res_Valid), 32'd0);
        alu_respond(0, 16'hBEEF);
        chk("race_res_valid", 32'(Res_Valid), 32'd1);
        collect();

        // backpressure: result held, new command not consumed
        issue(4'h3, 8'd11, 8'd22, 1'b0);
        sb.push_back({1'b0, 16'h1111});
        alu_respond(0, 16'h1111);
        for (int k = 0; k < 10; k++) begin
            ALU_Valid = k[0]; ALU_Result = 16'h2222;
            Cmd_Valid = 1'b1; Cmd_Fun = 4'h9; Cmd_A = 8'd9; Cmd_B = 8'd9;
            step();
            chk("bp_res_data", 32'(Res_Data), 32'h1111);
            chk("bp_res_valid", 32'(Res_Valid), 32'd1);
            chk("bp_cmd_ready", 32'(Cmd_Ready), 32'd0);
        end
        ALU_Valid = 1'b0;
        sb_check();
        chk("bp_a_not_consumed", 32'(ALU_A), 32'd11);
        Res_Ready = 1'b1;
        step();
        Res_Ready = 1'b0;
        chk("bp_idle_res_valid", 32'(Res_Valid), 32'd0);
        chk("bp_idle_cmd_ready", 32'(Cmd_Ready), 32'd1);
        step();
        Cmd_Valid = 1'b0;
        chk("bp_next_enable", 32'(Enable_ALU), 32'd1);
        chk("bp_next_a", 32'(ALU_A), 32'd9);
        chk("bp_next_fun", 32'(ALU_FUN), 32'h9);
        step();
        sb.push_back({1'b0, 16'h0051});
        alu_respond(2, 16'h0051);
        collect();

        // reset in the middle of WAIT drops the command
        issue(4'h6, 8'd77, 8'd88, 1'b0);
        step(); step();
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(Cmd_Ready), 32'd0);
        chk("mid_rst_alu_a", 32'(ALU_A), 32'd0);
        chk("mid_rst_alu_fun", 32'(ALU_FUN), 32'd0);
        chk("mid_rst_res_data", 32'(Res_Data), 32'd0);
        step();
        RST = 1'b1;
        ALU_Valid = 1'b1; ALU_Result = 16'h7777;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("late_valid_no_res", 32'(Res_Valid), 32'd0);
            chk("late_valid_idle", 32'(Busy), 32'd0);
        end
        ALU_Valid = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
